// File: rtl/hova_feeder.sv
// Slow-clock / core-reset generator and 6-bit instruction serialiser for the hovalaag core.
// Optional single-step control (run/step ports) is enabled by defining HOVA_FEEDER_STEP_EN.
module hova_feeder #(
  parameter int HALF_PERIOD   = 524288,
  parameter int RESET_PERIODS = 20
) (
  input  logic        clk12MHz,
  input  logic        reset_n,
`ifdef HOVA_FEEDER_STEP_EN
  input  logic        run,
  input  logic        step,
`endif
  input  logic [7:0]  tt_out,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        slow_clk,
  output logic        hova_rst_n,
  output logic [5:0]  tt_in,
  output logic [7:0]  pc,
  output logic [7:0]  out_val,
  output logic [3:0]  stage
);
  localparam int DIV_W = $clog2(HALF_PERIOD);
  localparam int RST_W = $clog2(RESET_PERIODS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_PERIODS - 1);
  localparam logic [RST_W-1:0] RST_SAT  = RST_W'(RESET_PERIODS);

  logic [DIV_W-1:0] r_div;
  logic [RST_W-1:0] r_rst_cnt;
  logic             r_slow_clk;
  logic             r_hova_rst_n;
  logic [3:0]       r_stage;
  logic [5:0]       r_tt_in;
  logic [7:0]       r_pc;
  logic [7:0]       r_out_val;
  logic [31:0]      r_cur_instr;
  logic [31:0]      r_ram [8] = '{default: '0};

  logic       w_adv;
  logic       w_wrap;
  logic       w_rise;
  logic       w_fall;
  logic [5:0] w_chunk;

  assign w_wrap = w_adv & (r_div == DIV_LAST);
  assign w_rise = w_wrap & ~r_slow_clk;
  assign w_fall = w_wrap &  r_slow_clk;

`ifdef HOVA_FEEDER_STEP_EN
  logic [2:0] r_step_sync;
  logic       r_stepping;
  logic       w_idle;
  logic       w_step_edge;

  // Parked at the start of a low half-period with no step period in flight.
  assign w_idle      = ~r_slow_clk & (r_div == '0) & ~r_stepping;
  assign w_step_edge = r_step_sync[1] & ~r_step_sync[2];
  assign w_adv       = run | ~w_idle;

  always_ff @(posedge clk12MHz) begin
    if (!reset_n) begin
      r_step_sync <= '0;
      r_stepping  <= 1'b0;
    end else begin
      r_step_sync <= {r_step_sync[1:0], step};
      if (w_fall)
        r_stepping <= 1'b0;
      else if (w_step_edge & ~run & w_idle)
        r_stepping <= 1'b1;
    end
  end
`else
  assign w_adv = 1'b1;
`endif

  always_comb begin
    w_chunk = '0;
    case (r_stage)
      4'd0:    w_chunk = r_cur_instr[5:0];
      4'd1:    w_chunk = r_cur_instr[11:6];
      4'd2:    w_chunk = r_cur_instr[17:12];
      4'd3:    w_chunk = r_cur_instr[23:18];
      4'd4:    w_chunk = r_cur_instr[29:24];
      4'd5:    w_chunk = {4'b0, r_cur_instr[31:30]};
      default: w_chunk = '0;
    endcase
  end

  // Instruction RAM is deliberately outside the reset domain.
  always_ff @(posedge clk12MHz) begin
    if (wr_en)
      r_ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk12MHz) begin
    if (!reset_n) begin
      r_div        <= '0;
      r_rst_cnt    <= '0;
      r_slow_clk   <= 1'b0;
      r_hova_rst_n <= 1'b0;
      r_stage      <= '0;
      r_tt_in      <= '0;
      r_pc         <= '0;
      r_out_val    <= '0;
      r_cur_instr  <= '0;
    end else begin
      if (w_adv)
        r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
      if (w_wrap)
        r_slow_clk <= ~r_slow_clk;
      if (w_rise) begin
        if (r_rst_cnt != RST_SAT)
          r_rst_cnt <= r_rst_cnt + RST_W'(1);
        if (r_rst_cnt == RST_LAST)
          r_hova_rst_n <= 1'b1;
        // Stage decision uses the pre-rise core reset state.
        if (!r_hova_rst_n || r_stage == 4'd9)
          r_stage <= '0;
        else
          r_stage <= r_stage + 4'd1;
        r_cur_instr <= r_ram[r_pc[2:0]];
      end
      if (w_fall) begin
        if (r_hova_rst_n) begin
          r_tt_in <= w_chunk;
          if (r_stage == 4'd7)
            r_pc <= tt_out;
          if (r_stage == 4'd0)
            r_out_val <= tt_out;
        end else begin
          r_tt_in <= '0;
        end
      end
    end
  end

  assign slow_clk   = r_slow_clk;
  assign hova_rst_n = r_hova_rst_n;
  assign tt_in      = r_tt_in;
  assign pc         = r_pc;
  assign out_val    = r_out_val;
  assign stage      = r_stage;

endmodule
